// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl shared types: state codes, RV32I opcodes, ALU op codes,
// ALU B-select codes, control bundle and an illegal-instruction helper.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_BR2,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Branch funct3 010/011/110/111 all have bit 1 set; SLT/SLTU on
  // OP and OP-IMM are funct3 01x.
  function automatic logic instr_illegal(
    input logic [6:0] opc,
    input logic [2:0] f3
  );
    logic ill;
    ill = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM: ill = (f3[2:1] == 2'b01);
      OPC_BRANCH:         ill = f3[1];
      OPC_LOAD, OPC_STORE,
      OPC_JAL, OPC_JALR,
      OPC_SYSTEM:         ill = 1'b0;
      default:            ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields, bcond and halt_req in;
// strobes, selects, alu_op and status out. master = controller side.
interface multicycle_ctrl_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       bcond;
  logic       halt_req;

  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_source;
  logic [2:0] alu_op;
  logic       is_halted;
  logic       is_illegal;

  modport master (
    input  opcode, funct3, funct7_5, bcond, halt_req,
    output pc_write, iord, mem_read, mem_write,
    output ir_write, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, pc_source,
    output alu_op, is_halted, is_illegal
  );

  modport slave (
    output opcode, funct3, funct7_5, bcond, halt_req,
    input  pc_write, iord, mem_read, mem_write,
    input  ir_write, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, pc_source,
    input  alu_op, is_halted, is_illegal
  );

endinterface

// File: rtl/multicycle_ctrl_alu_control.sv
// ALU op decode from state + IR fields. In: state, opcode, funct3,
// funct7_5. Out: alu_op (3-bit ALU encoding, ADD outside EX).
module multicycle_ctrl_alu_control
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_op
);

  logic       is_ex;
  logic       is_op;
  logic       is_opi;
  logic       is_br;
  logic [2:0] arith_op;
  logic [2:0] br_op;

  assign is_ex  = (state == S_EX);
  assign is_op  = (opcode == OPC_OP);
  assign is_opi = (opcode == OPC_OP_IMM);
  assign is_br  = (opcode == OPC_BRANCH);

  // OP-IMM bit 30 is immediate data for ADDI, so SUB is OP only.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (funct7_5 && is_op) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      3'b111:  arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  // The ALU's bcond logic reuses op codes for the compare kinds.
  always_comb begin
    br_op = ALU_ADD;
    case (funct3)
      3'b000:  br_op = ALU_ADD;
      3'b001:  br_op = ALU_SUB;
      3'b100:  br_op = ALU_SLL;
      3'b101:  br_op = ALU_XOR;
      default: br_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_ex && (is_op || is_opi): alu_op = arith_op;
      is_ex && is_br:             alu_op = br_op;
      default:                    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/BR2/HALT). Ports: clk,
// reset (sync, active-high), bus (multicycle_ctrl_if.master).
// Option: MC_CTRL_EARLY_BRANCH_TARGET_EN -> branch target in ID, taken
// branches retire in EX.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  logic       ill_q;
  logic       ill_d;
  ctrl_t      ctl;
  ctrl_t      ctl_o;
  logic [2:0] alu_op_raw;
  logic       illegal;

  logic c_op;
  logic c_opi;
  logic c_ld;
  logic c_st;
  logic c_br;
  logic c_jal;
  logic c_jalr;
  logic c_sys;

  assign c_op   = (bus.opcode == OPC_OP);
  assign c_opi  = (bus.opcode == OPC_OP_IMM);
  assign c_ld   = (bus.opcode == OPC_LOAD);
  assign c_st   = (bus.opcode == OPC_STORE);
  assign c_br   = (bus.opcode == OPC_BRANCH);
  assign c_jal  = (bus.opcode == OPC_JAL);
  assign c_jalr = (bus.opcode == OPC_JALR);
  assign c_sys  = (bus.opcode == OPC_SYSTEM);

  assign illegal = instr_illegal(bus.opcode, bus.funct3);

  multicycle_ctrl_alu_control u_alu_control (
    .state    (state_q),
    .opcode   (bus.opcode),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .alu_op   (alu_op_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
    end
  end

`ifndef MC_CTRL_EARLY_BRANCH_TARGET_EN
  // bcond is only meaningful while EX drives the compare; BR2 uses
  // this copy to pick PC+imm or PC+4.
  logic br_taken_q;

  always_ff @(posedge clk) begin
    if (reset)
      br_taken_q <= 1'b0;
    else if (state_q == S_EX)
      br_taken_q <= bus.bcond;
  end
`endif

  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    ctl     = CTRL_IDLE;
    unique case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = 1'b1;
        state_d      = S_ID;
      end
      S_ID: begin
`ifdef MC_CTRL_EARLY_BRANCH_TARGET_EN
        ctl.alu_src_b = SRC_B_IMM;
`endif
        if (illegal) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        unique case (1'b1)
          c_op: begin
            ctl.alu_src_a = 1'b1;
            state_d       = S_WB;
          end
          c_opi: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRC_B_IMM;
            state_d       = S_WB;
          end
          c_ld, c_st: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRC_B_IMM;
            state_d       = S_MEM;
          end
          c_br: begin
            ctl.alu_src_a = 1'b1;
`ifdef MC_CTRL_EARLY_BRANCH_TARGET_EN
            if (bus.bcond) begin
              ctl.pc_write  = 1'b1;
              ctl.pc_source = 1'b1;
              state_d       = S_IF;
            end else begin
              state_d = S_BR2;
            end
`else
            state_d = S_BR2;
`endif
          end
          c_jal, c_jalr: begin
            ctl.alu_src_b = SRC_B_FOUR;
            state_d       = S_WB;
          end
          c_sys: begin
            ctl.alu_src_b = SRC_B_FOUR;
            if (bus.halt_req) begin
              state_d = S_HALT;
            end else begin
              ctl.pc_write = 1'b1;
              state_d      = S_IF;
            end
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        ctl.iord = 1'b1;
        if (c_st) begin
          ctl.mem_write = 1'b1;
          ctl.alu_src_b = SRC_B_FOUR;
          ctl.pc_write  = 1'b1;
          state_d       = S_IF;
        end else begin
          ctl.mem_read = 1'b1;
          state_d      = S_WB;
        end
      end
      S_WB: begin
        ctl.reg_write = 1'b1;
        ctl.pc_write  = 1'b1;
        state_d       = S_IF;
        unique case (1'b1)
          c_ld: begin
            ctl.mem_to_reg = 1'b1;
            ctl.alu_src_b  = SRC_B_FOUR;
          end
          c_jal: begin
            ctl.alu_src_b = SRC_B_IMM;
          end
          c_jalr: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRC_B_IMM;
          end
          default: ctl.alu_src_b = SRC_B_FOUR;
        endcase
      end
      S_BR2: begin
        ctl.pc_write = 1'b1;
`ifdef MC_CTRL_EARLY_BRANCH_TARGET_EN
        ctl.alu_src_b = SRC_B_FOUR;
`else
        ctl.alu_src_b = br_taken_q ? SRC_B_IMM : SRC_B_FOUR;
`endif
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Reset overrides the state decode so nothing fires in that cycle.
  assign ctl_o = reset ? CTRL_IDLE : ctl;

  assign bus.pc_write   = ctl_o.pc_write;
  assign bus.iord       = ctl_o.iord;
  assign bus.mem_read   = ctl_o.mem_read;
  assign bus.mem_write  = ctl_o.mem_write;
  assign bus.ir_write   = ctl_o.ir_write;
  assign bus.mem_to_reg = ctl_o.mem_to_reg;
  assign bus.reg_write  = ctl_o.reg_write;
  assign bus.alu_src_a  = ctl_o.alu_src_a;
  assign bus.alu_src_b  = ctl_o.alu_src_b;
  assign bus.pc_source  = ctl_o.pc_source;
  assign bus.alu_op     = reset ? ALU_ADD : alu_op_raw;
  assign bus.is_halted  = !reset && (state_q == S_HALT);
  assign bus.is_illegal = !reset && ill_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle trace model plus literal pins.
// Honours MC_CTRL_EARLY_BRANCH_TARGET_EN like the design.
module tb_multicycle_ctrl;

  localparam logic [15:0] M_PCW = 16'h8000;
  localparam logic [15:0] M_IORD = 16'h4000;
  localparam logic [15:0] M_MRD = 16'h2000;
  localparam logic [15:0] M_MWR = 16'h1000;
  localparam logic [15:0] M_IRW = 16'h0800;
  localparam logic [15:0] M_M2R = 16'h0400;
  localparam logic [15:0] M_RW = 16'h0200;
  localparam logic [15:0] M_ASA = 16'h0100;
  localparam logic [15:0] M_ASB = 16'h00C0;
  localparam logic [15:0] M_PCS = 16'h0020;
  localparam logic [15:0] M_OP = 16'h001C;
  localparam logic [15:0] M_HLT = 16'h0002;
  localparam logic [15:0] M_ILL = 16'h0001;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] LUI = 7'b0110111;

  // ALU code per funct3: ADD SLL - - XOR SRL OR AND
  localparam logic [2:0] OPTAB[8] = '{
    3'd0, 3'd2, 3'd0, 3'd0, 3'd3, 3'd6, 3'd4, 3'd5};
  // beq=ADD bne=SUB blt=SLL bge=XOR
  localparam logic [2:0] BOPT[8] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd0, 3'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  logic [15:0] exp_q[$];
  logic [15:0] lit_m[$];
  logic [15:0] lit_v[$];
  logic [15:0] d_v;
  logic [15:0] e_v;
  logic [15:0] l_m;
  logic [15:0] l_v;

  logic [6:0] n_opc;
  logic [2:0] n_f3;
  logic n_f7;
  logic n_hr;

  function automatic logic [15:0] dut_vec();
    return {bus.pc_write, bus.iord, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.pc_source, bus.alu_op, bus.is_halted,
            bus.is_illegal};
  endfunction

  function automatic logic [15:0] sb(input logic [1:0] b);
    return {8'b0, b, 6'b0};
  endfunction

  function automatic logic [15:0] ao(input logic [2:0] op);
    return {11'b0, op, 2'b0};
  endfunction

  // SUB/SRA are the next code after ADD/SRL.
  function automatic logic [2:0] arith(
    input logic [2:0] f3, input logic f7, input logic rr);
    logic [2:0] op;
    op = OPTAB[f3];
    if (f7 && (f3 == 3'd5 || (rr && f3 == 3'd0)))
      op = op + 3'd1;
    return op;
  endfunction

  function automatic logic is_ill(
    input logic [6:0] opc, input logic [2:0] f3);
    if (!(opc inside {LD, ST, OP, OPI, BR, JAL, JALR, SYS}))
      return 1'b1;
    if ((opc == OP || opc == OPI) && (f3 inside {3'd2, 3'd3}))
      return 1'b1;
    if (opc == BR && !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5}))
      return 1'b1;
    return 1'b0;
  endfunction

  localparam logic [15:0] V_FETCH = M_MRD | M_IRW;
  localparam logic [15:0] V_PC4 = M_PCW | 16'h0040;
`ifdef MC_CTRL_EARLY_BRANCH_TARGET_EN
  localparam logic [15:0] V_DEC = 16'h0080;
  localparam bit EARLY = 1'b1;
`else
  localparam logic [15:0] V_DEC = 16'h0000;
  localparam bit EARLY = 1'b0;
`endif

  always @(negedge clk) begin
    d_v = dut_vec();
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      n_cmp++;
      if (d_v !== e_v) begin
        n_bad++;
        $display("FAIL trace cyc=%0d got=%h want=%h",
                 cyc_no, d_v, e_v);
      end
    end
    if (lit_m.size() > 0) begin
      l_m = lit_m.pop_front();
      l_v = lit_v.pop_front();
      n_cmp++;
      if ((d_v & l_m) !== l_v) begin
        n_bad++;
        $display("FAIL pin cyc=%0d mask=%h got=%h want=%h",
                 cyc_no, l_m, d_v & l_m, l_v);
      end
    end
    cyc_no++;
  end

  task automatic cyc(
    input logic [15:0] e, input logic bc, input logic rst,
    input logic ld = 1'b0,
    input logic [15:0] lm = 16'h0, input logic [15:0] lv = 16'h0);
    @(posedge clk);
    #1;
    reset = rst;
    bus.bcond = bc;
    if (ld) begin
      bus.opcode = n_opc;
      bus.funct3 = n_f3;
      bus.funct7_5 = n_f7;
      bus.halt_req = n_hr;
    end
    exp_q.push_back(e);
    if (lm != 16'h0) begin
      lit_m.push_back(lm);
      lit_v.push_back(lv);
    end
  endtask

  // bcond is driven inverted outside EX so a stray sample shows up.
  task automatic instr(
    input logic [6:0] opc, input logic [2:0] f3, input logic f7,
    input logic bc, input logic hr, input int pin = -1,
    input logic [15:0] pm = 16'h0, input logic [15:0] pv = 16'h0,
    input int halt_n = 3);
    logic [15:0] q[$];
    logic [15:0] ex;
    n_opc = opc;
    n_f3 = f3;
    n_f7 = f7;
    n_hr = hr;
    q.push_back(V_FETCH);
    q.push_back(V_DEC);
    if (is_ill(opc, f3)) begin
      for (int i = 0; i < halt_n; i++)
        q.push_back(M_HLT | M_ILL);
    end else begin
      case (opc)
        OP: begin
          q.push_back(M_ASA | ao(arith(f3, f7, 1'b1)));
          q.push_back(M_RW | V_PC4);
        end
        OPI: begin
          q.push_back(M_ASA | sb(2'd2) | ao(arith(f3, f7, 1'b0)));
          q.push_back(M_RW | V_PC4);
        end
        LD: begin
          q.push_back(M_ASA | sb(2'd2));
          q.push_back(M_MRD | M_IORD);
          q.push_back(M_RW | M_M2R | V_PC4);
        end
        ST: begin
          q.push_back(M_ASA | sb(2'd2));
          q.push_back(M_MWR | M_IORD | V_PC4);
        end
        BR: begin
          ex = M_ASA | ao(BOPT[f3]);
          if (EARLY && bc) begin
            q.push_back(ex | M_PCW | M_PCS);
          end else begin
            q.push_back(ex);
            q.push_back(M_PCW | sb((bc && !EARLY) ? 2'd2 : 2'd1));
          end
        end
        JAL: begin
          q.push_back(sb(2'd1));
          q.push_back(M_RW | M_PCW | sb(2'd2));
        end
        JALR: begin
          q.push_back(sb(2'd1));
          q.push_back(M_RW | M_PCW | M_ASA | sb(2'd2));
        end
        default: begin
          q.push_back(sb(2'd1) | (hr ? 16'h0 : M_PCW));
          if (hr)
            for (int i = 0; i < halt_n; i++)
              q.push_back(M_HLT);
        end
      endcase
    end
    for (int k = 0; k < q.size(); k++)
      cyc(q[k], (k == 2) ? bc : !bc, 1'b0, k == 0,
          (k == pin) ? pm : 16'h0, pv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.opcode = 7'h0;
    bus.funct3 = 3'h0;
    bus.funct7_5 = 1'b0;
    bus.bcond = 1'b0;
    bus.halt_req = 1'b0;
    n_opc = OP;
    n_f3 = 3'd0;
    n_f7 = 1'b0;
    n_hr = 1'b0;

    cyc(16'h0, 1'b0, 1'b1);
    cyc(16'h0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0000);

    instr(OP, 3'd0, 1'b0, 1'b0, 1'b0, 3, M_RW | M_PCW, M_RW | M_PCW);
    instr(OP, 3'd0, 1'b0, 1'b0, 1'b0, 2, M_OP | M_PCW, 16'h0);
    instr(OP, 3'd0, 1'b1, 1'b0, 1'b0, 2, M_OP, ao(3'd1));
    instr(OP, 3'd5, 1'b1, 1'b0, 1'b0, 2, M_OP, ao(3'd7));
    instr(OP, 3'd7, 1'b0, 1'b0, 1'b0);
    instr(OP, 3'd6, 1'b0, 1'b0, 1'b0);
    instr(OP, 3'd1, 1'b0, 1'b0, 1'b0);
    instr(OPI, 3'd0, 1'b1, 1'b0, 1'b0, 2, M_OP | M_ASB, sb(2'd2));
    instr(OPI, 3'd5, 1'b1, 1'b0, 1'b0);
    instr(OPI, 3'd4, 1'b0, 1'b0, 1'b0);
    instr(LD, 3'd2, 1'b0, 1'b0, 1'b0, 3,
          M_MRD | M_IORD | M_PCW, M_MRD | M_IORD);
    instr(LD, 3'd2, 1'b0, 1'b0, 1'b0, 4, M_M2R | M_RW, M_M2R | M_RW);
    instr(ST, 3'd2, 1'b0, 1'b0, 1'b0, 3, M_MWR | M_IORD, M_MWR | M_IORD);

    instr(BR, 3'd4, 1'b0, 1'b1, 1'b0, 2, M_OP, ao(3'd2));
`ifdef MC_CTRL_EARLY_BRANCH_TARGET_EN
    instr(BR, 3'd4, 1'b0, 1'b1, 1'b0, 2,
          M_PCW | M_PCS, M_PCW | M_PCS);
`else
    instr(BR, 3'd4, 1'b0, 1'b1, 1'b0, 3,
          M_ASB | M_PCW, sb(2'd2) | M_PCW);
`endif
    instr(BR, 3'd1, 1'b0, 1'b0, 1'b0, 3,
          M_ASB | M_PCW | M_PCS, sb(2'd1) | M_PCW);
    instr(BR, 3'd0, 1'b0, 1'b1, 1'b0);
    instr(BR, 3'd5, 1'b0, 1'b0, 1'b0);
    instr(BR, 3'd5, 1'b0, 1'b1, 1'b0);
    instr(JAL, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(JALR, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(SYS, 3'd0, 1'b0, 1'b0, 1'b0, 2, M_PCW, M_PCW);

    instr(OPI, 3'd2, 1'b0, 1'b0, 1'b0, 2,
          M_HLT | M_ILL, M_HLT | M_ILL);
    cyc(16'h0, 1'b0, 1'b1);
    instr(BR, 3'd6, 1'b0, 1'b1, 1'b0);
    cyc(16'h0, 1'b0, 1'b1);
    instr(LUI, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(16'h0, 1'b0, 1'b1);

    // sw aborted by reset in MEM
    n_opc = ST;
    n_f3 = 3'd2;
    n_f7 = 1'b0;
    n_hr = 1'b0;
    cyc(V_FETCH, 1'b0, 1'b0, 1'b1);
    cyc(V_DEC, 1'b0, 1'b0);
    cyc(M_ASA | sb(2'd2), 1'b0, 1'b0);
    cyc(16'h0, 1'b0, 1'b1, 1'b0, M_MWR | M_PCW, 16'h0);
    instr(OP, 3'd0, 1'b0, 1'b0, 1'b0);

    instr(SYS, 3'd0, 1'b0, 1'b0, 1'b1, 12,
          16'hFFFF, M_HLT, 11);
    cyc(16'h0, 1'b0, 1'b1, 1'b0, M_HLT, 16'h0);
    instr(OP, 3'd0, 1'b0, 1'b0, 1'b0, 0, V_FETCH, V_FETCH);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
